// File: rtl/des_feistel_combine_if.sv
// Handshake and data bundle for one DES Feistel round-combine stage.
// The slave side is the combine block; the master side is its driver/consumer.
interface des_feistel_combine_if #(
  parameter int HALF_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_first;
  logic [HALF_WIDTH-1:0] l_in;
  logic [HALF_WIDTH-1:0] r_in;
  logic [HALF_WIDTH-1:0] sbox_out;
  logic                  out_valid;
  logic                  out_ready;
  logic [HALF_WIDTH-1:0] l_out;
  logic [HALF_WIDTH-1:0] r_out;
  logic                  out_last;
  logic                  seq_err;

  modport slave (
    input  in_valid, in_first, l_in, r_in, sbox_out, out_ready,
    output in_ready, out_valid, l_out, r_out, out_last, seq_err
  );

  modport master (
    output in_valid, in_first, l_in, r_in, sbox_out, out_ready,
    input  in_ready, out_valid, l_out, r_out, out_last, seq_err
  );
endinterface

// File: rtl/des_feistel_combine.sv
// DES round combine: P-permutes the S-box output, XORs it into the left half
// and swaps halves (except on round 15), behind a single-register valid/ready stage.
module des_feistel_combine #(
  parameter int HALF_WIDTH = 32,
  parameter int ROUNDS     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  des_feistel_combine_if.slave  bus
);
  localparam logic [3:0] LAST_RND = 4'(ROUNDS - 1);
  // DES P table, 1-based with bit 1 = MSB: output bit i takes input bit P_TAB[i-1]
  localparam int P_TAB [32] = '{16,  7, 20, 21, 29, 12, 28, 17,
                                 1, 15, 23, 26,  5, 18, 31, 10,
                                 2,  8, 24, 14, 32, 27,  3,  9,
                                19, 13, 30,  6, 22, 11,  4, 25};

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  vld_q;
  logic                  last_q;
  logic [HALF_WIDTH-1:0] l_q, r_q;
  logic [HALF_WIDTH-1:0] f;
  logic                  acc;
  logic [3:0]            rnd;
  logic                  last_rnd;

  for (genvar g = 0; g < 32; g++) begin : g_perm
    assign f[HALF_WIDTH-1-g] = bus.sbox_out[HALF_WIDTH-P_TAB[g]];
  end

  assign bus.in_ready  = !vld_q || bus.out_ready;
  assign acc           = bus.in_valid && bus.in_ready;
  // in_first always restarts; an unflagged beat in IDLE is still treated as round 0
  assign rnd           = (bus.in_first || state_q == IDLE) ? 4'd0 : cnt_q;
  assign last_rnd      = (rnd == LAST_RND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (acc) begin
      if ((bus.in_first && state_q == RUN) || (!bus.in_first && state_q == IDLE))
        err_d = 1'b1;
      if (last_rnd) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        state_d = RUN;
        cnt_d   = rnd + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      last_q <= 1'b0;
      l_q    <= '0;
      r_q    <= '0;
    end else if (acc) begin
      vld_q  <= 1'b1;
      last_q <= last_rnd;
      l_q    <= last_rnd ? (bus.l_in ^ f) : bus.r_in;
      r_q    <= last_rnd ? bus.r_in : (bus.l_in ^ f);
    end else if (bus.out_ready) begin
      vld_q  <= 1'b0;
    end
  end

  assign bus.out_valid = vld_q;
  assign bus.out_last  = last_q;
  assign bus.l_out     = l_q;
  assign bus.r_out     = r_q;
  assign bus.seq_err   = err_q;
endmodule

// File: tb/tb_des_feistel_combine.sv
// Scoreboard bench for des_feistel_combine: a round/sequence model pushes
// expected beats on accept; a negedge monitor pops and compares on pop.
module tb_des_feistel_combine;
  logic clk;
  logic rst_n;
  des_feistel_combine_if #(.HALF_WIDTH(32)) bus();

  des_feistel_combine #(.HALF_WIDTH(32), .ROUNDS(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] l;
    logic [31:0] r;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   m_run;
  int   m_cnt;
  bit   m_err;

  localparam int P [32] = '{16,  7, 20, 21, 29, 12, 28, 17,
                             1, 15, 23, 26,  5, 18, 31, 10,
                             2,  8, 24, 14, 32, 27,  3,  9,
                            19, 13, 30,  6, 22, 11,  4, 25};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] perm(input logic [31:0] s);
    logic [31:0] o;
    o = '0;
    for (int i = 1; i <= 32; i++) o[32-i] = s[32-P[i-1]];
    return o;
  endfunction

  // push the expected result of an accepted beat and advance the sequence model
  task automatic model_push(input bit first, input logic [31:0] l, input logic [31:0] r,
                            input logic [31:0] s);
    exp_t e;
    int   rnd;
    logic [31:0] f;
    if ((first && m_run) || (!first && !m_run)) m_err = 1'b1;
    rnd = (first || !m_run) ? 0 : m_cnt;
    f   = perm(s);
    if (rnd == 15) begin
      e.l = l ^ f; e.r = r; e.last = 1'b1;
      m_run = 1'b0; m_cnt = 0;
    end else begin
      e.l = r; e.r = l ^ f; e.last = 1'b0;
      m_run = 1'b1; m_cnt = rnd + 1;
    end
    sb.push_back(e);
  endtask

  // called at posedge+1; returns at posedge+1 right after the accepting edge
  task automatic beat(input bit first, input logic [31:0] l, input logic [31:0] r,
                      input logic [31:0] s);
    bit done;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_first = first;
    bus.l_in     = l;
    bus.r_in     = r;
    bus.sbox_out = s;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        model_push(first, l, r, s);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
    chk("seq_err", 32'(bus.seq_err), 32'(m_err));
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    sb.delete();
    m_run = 1'b0; m_cnt = 0; m_err = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("spurious_out", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("l_out", bus.l_out, e.l);
        chk("r_out", bus.r_out, e.r);
        chk("out_last", 32'(bus.out_last), 32'(e.last));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_first = 1'b0;
    bus.l_in = '0; bus.r_in = '0; bus.sbox_out = '0;
    bus.out_ready = 1'b1;
    m_run = 1'b0; m_cnt = 0; m_err = 1'b0;
    #2;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_l_out", bus.l_out, 32'd0);
    chk("rst_r_out", bus.r_out, 32'd0);
    chk("rst_out_last", 32'(bus.out_last), 32'd0);
    chk("rst_seq_err", 32'(bus.seq_err), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // permutation corners: S1 MSB and S8 LSB
    beat(1'b1, 32'h0, 32'h0, 32'h8000_0000);
    chk("perm_msb_l", bus.l_out, 32'h0000_0000);
    chk("perm_msb_r", bus.r_out, 32'h0080_0000);
    idle(1);
    do_reset();
    beat(1'b1, 32'h0, 32'h0, 32'h0000_0001);
    chk("perm_lsb_r", bus.r_out, 32'h0000_0800);
    idle(1);

    // swap round
    do_reset();
    beat(1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 32'h8000_0000);
    chk("swap_l", bus.l_out, 32'h1234_5678);
    chk("swap_r", bus.r_out, 32'hFF7F_FFFF);
    chk("swap_last", 32'(bus.out_last), 32'd0);
    idle(1);

    // full 16-round block back to back, then a clean new block (FSM back in IDLE)
    do_reset();
    for (int i = 0; i < 15; i++) beat(i == 0, $urandom, $urandom, $urandom);
    beat(1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 32'h8000_0000);
    chk("last_l", bus.l_out, 32'hFF7F_FFFF);
    chk("last_r", bus.r_out, 32'h1234_5678);
    chk("last_flag", 32'(bus.out_last), 32'd1);
    beat(1'b1, $urandom, $urandom, $urandom);
    chk("new_block_no_err", 32'(bus.seq_err), 32'd0);
    for (int i = 1; i < 16; i++) beat(1'b0, $urandom, $urandom, $urandom);
    idle(2);

    // backpressure: output held, then pop and accept on the same edge
    do_reset();
    bus.out_ready = 1'b0;
    beat(1'b1, $urandom, $urandom, $urandom);
    bus.in_valid = 1'b1; bus.in_first = 1'b0;
    bus.l_in = 32'hA5A5_0F0F; bus.r_in = 32'h3C3C_C3C3; bus.sbox_out = 32'h1357_9BDF;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_l_hold", bus.l_out, sb[0].l);
      chk("bp_r_hold", bus.r_out, sb[0].r);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    beat(1'b0, 32'hA5A5_0F0F, 32'h3C3C_C3C3, 32'h1357_9BDF);
    chk("bp_reload_valid", 32'(bus.out_valid), 32'd1);
    idle(2);

    // restart mid-block: sticky seq_err, counter restarts at round 0
    do_reset();
    for (int i = 0; i < 5; i++) beat(i == 0, $urandom, $urandom, $urandom);
    beat(1'b1, $urandom, $urandom, $urandom);
    chk("seq_err_set", 32'(bus.seq_err), 32'd1);
    for (int i = 1; i < 16; i++) beat(1'b0, $urandom, $urandom, $urandom);
    chk("restart_last", 32'(bus.out_last), 32'd1);
    chk("seq_err_sticky", 32'(bus.seq_err), 32'd1);
    idle(1);
    do_reset();
    chk("seq_err_cleared", 32'(bus.seq_err), 32'd0);

    // beat without in_first while idle: error, processed as round 0
    beat(1'b0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 32'h8000_0001);
    chk("idle_nofirst_err", 32'(bus.seq_err), 32'd1);
    chk("idle_nofirst_l", bus.l_out, 32'h0BAD_F00D);
    idle(1);

    // asynchronous reset between edges with a held output
    do_reset();
    bus.out_ready = 1'b0;
    beat(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("ar_pre_valid", 32'(bus.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 32'(bus.out_valid), 32'd0);
    chk("ar_l_out", bus.l_out, 32'd0);
    chk("ar_r_out", bus.r_out, 32'd0);
    chk("ar_in_ready", 32'(bus.in_ready), 32'd1);
    sb.delete();
    m_run = 1'b0; m_cnt = 0; m_err = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    beat(1'b1, $urandom, $urandom, $urandom);
    idle(3);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/des_feistel_combine.md
DES_FEISTEL_COMBINE -- requirements
Module: des_feistel_combine

Interface
REQ-001 The block SHALL have parameter HALF_WIDTH, default 32, meaning the width of one Feistel half; only 32 is supported.
REQ-002 The block SHALL have parameter ROUNDS, default 16, meaning the number of rounds per block; only 16 is supported.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-004 Port clk: input, 1 bit, rising-edge clock for all state.
REQ-005 Port rst_n: input, 1 bit, asynchronous active-low reset.
REQ-006 Port in_valid: input, 1 bit, upstream beat valid.
REQ-007 Port in_ready: output, 1 bit, block can accept a beat.
REQ-008 Port in_first: input, 1 bit, beat is round 0 of a new block.
REQ-009 Port l_in: input, 32 bits, left half entering this round.
REQ-010 Port r_in: input, 32 bits, right half entering this round.
REQ-011 Port sbox_out: input, 32 bits, concatenated S1..S8 outputs; S1 occupies [31:28] and S8 occupies [3:0].
REQ-012 Port out_valid: output, 1 bit, output beat valid.
REQ-013 Port out_ready: input, 1 bit, downstream accepts the output beat.
REQ-014 Port l_out: output, 32 bits, left half after this round.
REQ-015 Port r_out: output, 32 bits, right half after this round.
REQ-016 Port out_last: output, 1 bit, beat is round 15, so the block result is pre-IP^-1.
REQ-017 Port seq_err: output, 1 bit, sticky round-sequence error flag.

Function
REQ-018 The block SHALL compute f = P(sbox_out) using the DES P table, with bit 1 as the MSB: 16 7 20 21 29 12 28 17 1 15 23 26 5 18 31 10 2 8 24 14 32 27 3 9 19 13 30 6 22 11 4 25.
- Output bit i takes input bit P[i].
REQ-019 A beat SHALL be accepted on a rising clk edge when in_valid and in_ready are both high.
REQ-020 in_ready SHALL equal (!out_valid || out_ready), a single-register pipeline with no combinational path from in_valid to out_valid.
REQ-021 On an accepted beat with round count < 15, the output register SHALL load l_out = r_in and r_out = l_in ^ f (swap).
REQ-022 On an accepted beat with round count == 15, the output register SHALL load l_out = l_in ^ f and r_out = r_in (no swap), and set out_last = 1.
REQ-023 Latency SHALL be exactly 1 cycle: accept at edge N gives out_valid high after edge N.
REQ-024 out_valid, l_out, r_out and out_last SHALL hold stable while out_valid && !out_ready.
REQ-025 out_valid SHALL clear at the edge where out_ready is high and no new beat is accepted.
REQ-026 A simultaneous output pop and input accept SHALL reload the register with the new beat, keeping out_valid = 1.
REQ-027 The internal 4-bit round counter SHALL work as follows:
- It is loaded to 1 on an accepted beat with in_first = 1, which is treated as round 0.
- Otherwise it increments on each accepted beat.
- It wraps 15 -> 0 after the round-15 beat.
REQ-028 The FSM SHALL have states IDLE (counter 0, expecting in_first) and RUN (rounds 1..15 in progress).
- IDLE -> RUN on accept with in_first.
- RUN -> IDLE on accepting round 15.
REQ-029 seq_err SHALL set and remain set until reset in either case:
- an accepted beat has in_first = 1 while in RUN; the block restarts at round 0 anyway;
- an accepted beat has in_first = 0 while in IDLE; the beat is processed as round 0 and the FSM enters RUN.
REQ-030 Unaccepted inputs SHALL have no effect on any state.

Reset
REQ-031 On rst_n low, regardless of clk, the block SHALL immediately drive:
- out_valid = 0, out_last = 0, seq_err = 0;
- l_out = 0, r_out = 0;
- counter = 0, FSM = IDLE.
REQ-032 in_ready SHALL read 1 during and after reset.
REQ-033 Reset asserted mid-block SHALL discard the pending output beat and the round progress.
REQ-034 Deassertion of rst_n SHALL be synchronised to clk by the integrator; the block uses rst_n only as an asynchronous clear.

Verification
REQ-035 Permutation check:
- sbox_out = 0x80000000, l_in = 0, r_in = 0, in_first = 1 -> next cycle l_out = 0, r_out = 0x00800000.
- sbox_out = 0x00000001 -> r_out = 0x00000800.
REQ-036 Swap round: l_in = 0xFFFFFFFF, r_in = 0x12345678, sbox_out = 0x80000000, in_first = 1 -> l_out = 0x12345678, r_out = 0xFF7FFFFF, out_last = 0.
REQ-037 Last round: 16 back-to-back beats starting with in_first, with the final beat carrying l_in = 0xFFFFFFFF, r_in = 0x12345678, sbox_out = 0x80000000 -> on the 16th output, l_out = 0xFF7FFFFF, r_out = 0x12345678, out_last = 1; FSM is in IDLE afterwards.
REQ-038 Backpressure: hold out_ready = 0 for 3 cycles with in_valid = 1 -> in_ready = 0 and the output is stable for all 3 cycles; then out_ready = 1 -> the pop and the next accept occur on the same edge.
REQ-039 Sequence error: after 5 accepted rounds, send a beat with in_first = 1 -> seq_err = 1, the counter restarts, and seq_err stays 1 until rst_n pulses low.
REQ-040 Async reset: assert rst_n low between clock edges while out_valid = 1 -> out_valid, l_out and r_out go to 0 before the next clk edge.
